// File: rtl/key_irq_ctrl.sv
// Purpose: Avalon-MM key controller: 2-FF sync, optional per-key debounce, sticky edge capture, maskable level IRQ.
// Latency: in_port -> stable is 2 + DEBOUNCE_CYCLES clocks with KEY_DEBOUNCE_EN defined, 3 clocks without; readdata 1 clock; irq 1 clock after its registers.
// Backpressure: none; the slave has zero wait states and accepts a read or write every cycle.
module key_irq_ctrl #(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16,
   parameter bit          EDGE_RISING     = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   // Reject configurations the counter or register map cannot represent.
   if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_bad_cfg
      $error("key_irq_ctrl: illegal WIDTH/DEBOUNCE_CYCLES/CNT_W combination");
   end

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] stable_q, stable_dly_q;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] edge_hit, cap_w1c;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic             wr_en;
   logic             unused_wdata;

   // Two-flop synchronizer for the asynchronous key pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= in_port;
         sync2_q <= sync1_q;
      end
   end

`ifdef KEY_DEBOUNCE_EN
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } db_state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   db_state_e        state_q [WIDTH];
   db_state_e        state_d [WIDTH];
   logic [CNT_W-1:0] cnt_q   [WIDTH];
   logic [CNT_W-1:0] cnt_d   [WIDTH];
   logic [WIDTH-1:0] stable_d;

   // Debounce state, counters and accepted level per key.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
         end
         stable_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   // A changed level is accepted only after it has held for DEBOUNCE_CYCLES clocks.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_IDLE: begin
               if (sync2_q[i] != stable_q[i]) begin
                  // First disagreeing cycle counts as cycle one.
                  cnt_d[i]   = CNT_W'(1);
                  state_d[i] = ST_COUNT;
               end else begin
                  cnt_d[i] = '0;
               end
            end
            ST_COUNT: begin
               if (sync2_q[i] == stable_q[i]) begin
                  // Glitch returned to the accepted level: discard it.
                  cnt_d[i]   = '0;
                  state_d[i] = ST_IDLE;
               end else if (cnt_q[i] == CNT_LAST) begin
                  stable_d[i] = sync2_q[i];
                  cnt_d[i]    = '0;
                  state_d[i]  = ST_IDLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               cnt_d[i]   = '0;
               state_d[i] = ST_IDLE;
            end
         endcase
      end
   end
`else
   // Without debounce the accepted level simply follows the synchronizer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= '0;
      end else begin
         stable_q <= sync2_q;
      end
   end
`endif

   assign edge_hit     = EDGE_RISING ? (~stable_dly_q & stable_q) : (stable_dly_q & ~stable_q);
   assign wr_en        = chipselect & write;
   assign cap_w1c      = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^{1'b0, writedata};

   // Register-file next state: W1C loses to a same-cycle edge, readdata muxed every cycle.
   always_comb begin
      mask_d     = mask_q;
      edgecap_d  = (edgecap_q & ~cap_w1c) | edge_hit;
      irq_d      = |(edgecap_q & mask_q);
      readdata_d = '0;
      if (wr_en && address == 2'd2) begin
         mask_d = writedata[WIDTH-1:0];
      end
      case (address)
         2'd0:    readdata_d = 32'(stable_q);
         2'd2:    readdata_d = 32'(mask_q);
         2'd3:    readdata_d = 32'(edgecap_q);
         default: readdata_d = '0;
      endcase
   end

   // Edge history, mask, capture, read data and irq registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_dly_q <= '0;
         mask_q       <= '0;
         edgecap_q    <= '0;
         readdata_q   <= '0;
         irq_q        <= 1'b0;
      end else begin
         stable_dly_q <= stable_q;
         mask_q       <= mask_d;
         edgecap_q    <= edgecap_d;
         readdata_q   <= readdata_d;
         irq_q        <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
